// File: rtl/dsp_pack_pkg.sv
// Shared types and constants for the packed SIMD DSP issue stage.
package dsp_pack_pkg;

  localparam int DEFAULT_LANES = 4;
  localparam int DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } pack_state_e;

  // Lane index width; never narrower than one bit.
  function automatic int lane_idx_w(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/dsp_pack_lat_pipe.sv
// Valid-only delay line matching the DSP primitive latency; its tap is the result capture strobe.
module dsp_pack_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic start_i,
  output logic done_o
);

  logic [DEPTH-1:0] pipe_q;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) pipe_q <= '0;
      else           pipe_q <= start_i;
    end
  end else begin : g_deep
    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) pipe_q <= '0;
      else           pipe_q <= {pipe_q[DEPTH-2:0], start_i};
    end
  end

  assign done_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dsp_simd_packer.sv
// Packs scalar operand pairs into one SIMD vector for the external DSP adder and drains lane results in order.
// Optional issue/padding counters are built when DSP_SIMD_PACKER_STATS_EN is defined.
//
//   state    | meaning
//   ST_FILL  | accepting ops into lanes; idle timer runs while a partial vector is held
//   ST_WAIT  | vector issued, waiting for the DSP result
//   ST_DRAIN | emitting captured lane results 0..n_valid-1
module dsp_simd_packer
  import dsp_pack_pkg::*;
#(
  parameter  int LANES       = DEFAULT_LANES,
  parameter  int WIDTH       = DEFAULT_WIDTH,
  parameter  int TIMEOUT     = 8,
  parameter  int DSP_LATENCY = 1,
  localparam int LW          = lane_idx_w(LANES),
  localparam int VW          = LANES * WIDTH
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic             vec_valid_o,
  output logic [VW-1:0]    vec_a_o,
  output logic [VW-1:0]    vec_b_o,
  input  logic [VW-1:0]    vec_y_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_y_o,
  output logic [LW-1:0]    out_lane_o
`ifdef DSP_SIMD_PACKER_STATS_EN
  ,
  output logic [31:0]      stat_issued_o,
  output logic [31:0]      stat_padded_o
`endif
);

  localparam int CW = $clog2(LANES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  pack_state_e      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    n_valid_q, n_valid_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [VW-1:0]    vec_a_q, vec_a_d;
  logic [VW-1:0]    vec_b_q, vec_b_d;
  logic [VW-1:0]    res_q, res_d;
  logic             vec_valid_q, vec_valid_d;
  logic             alive_q;
  logic             accept;
  logic             full;
  logic             expire;
  logic             capture;
  logic [WIDTH-1:0] res_lane [LANES];

  dsp_pack_lat_pipe #(
    .DEPTH (DSP_LATENCY)
  ) u_lat_pipe (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .start_i  (vec_valid_q),
    .done_o   (capture)
  );

  // in_ready stays low while reset is held and rises on the first edge after release.
  assign in_ready_o = alive_q && (state_q == ST_FILL);
  assign accept     = in_valid_i && in_ready_o;
  assign full       = accept && (count_q == CW'(LANES - 1));
  assign expire     = !accept && (count_q != '0) && (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    n_valid_d   = n_valid_q;
    timer_d     = timer_q;
    lane_d      = lane_q;
    vec_a_d     = vec_a_q;
    vec_b_d     = vec_b_q;
    res_d       = res_q;
    vec_valid_d = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          for (int i = 0; i < LANES; i++) begin
            if (count_q == CW'(i)) begin
              vec_a_d[i*WIDTH +: WIDTH] = in_a_i;
              vec_b_d[i*WIDTH +: WIDTH] = in_b_i;
            end
          end
          count_d = count_q + CW'(1);
          timer_d = '0;
        end else if (count_q != '0) begin
          timer_d = timer_q + TW'(1);
        end
        // Unfilled lanes are still zero from the last clear, so they go out as padding.
        if (full || expire) begin
          state_d     = ST_WAIT;
          vec_valid_d = 1'b1;
          n_valid_d   = count_d;
        end
      end

      ST_WAIT: begin
        if (capture) begin
          res_d   = vec_y_i;
          lane_d  = '0;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (out_ready_i) begin
          if ((CW'(lane_q) + CW'(1)) == n_valid_q) begin
            state_d = ST_FILL;
            count_d = '0;
            timer_d = '0;
            lane_d  = '0;
            vec_a_d = '0;
            vec_b_d = '0;
            res_d   = '0;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end

      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      n_valid_q   <= '0;
      timer_q     <= '0;
      lane_q      <= '0;
      vec_a_q     <= '0;
      vec_b_q     <= '0;
      res_q       <= '0;
      vec_valid_q <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      n_valid_q   <= n_valid_d;
      timer_q     <= timer_d;
      lane_q      <= lane_d;
      vec_a_q     <= vec_a_d;
      vec_b_q     <= vec_b_d;
      res_q       <= res_d;
      vec_valid_q <= vec_valid_d;
      alive_q     <= 1'b1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign res_lane[g] = res_q[g*WIDTH +: WIDTH];
  end

  assign vec_valid_o = vec_valid_q;
  assign vec_a_o     = vec_a_q;
  assign vec_b_o     = vec_b_q;
  assign out_valid_o = (state_q == ST_DRAIN);
  assign out_y_o     = res_lane[lane_q];
  assign out_lane_o  = lane_q;

`ifdef DSP_SIMD_PACKER_STATS_EN
  logic [31:0] stat_issued_q;
  logic [31:0] stat_padded_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stat_issued_q <= '0;
      stat_padded_q <= '0;
    end else if (vec_valid_d) begin
      stat_issued_q <= stat_issued_q + 32'd1;
      stat_padded_q <= stat_padded_q + 32'(LANES) - 32'(count_d);
    end
  end

  assign stat_issued_o = stat_issued_q;
  assign stat_padded_o = stat_padded_q;
`endif

endmodule

// File: tb/tb_dsp_simd_packer.sv
// Randomized bench for dsp_simd_packer against a transaction-level model with a per-lane-add DSP.
module tb_dsp_simd_packer;
  import dsp_pack_pkg::*;

  localparam int LANES = 4;
  localparam int W     = 12;
  localparam int TO    = 8;
  localparam int LAT   = 1;
  localparam int VW    = LANES * W;
  localparam int LW    = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          vec_valid;
  logic [VW-1:0] vec_a, vec_b, vec_y;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_y;
  logic [LW-1:0] out_lane;
`ifdef DSP_SIMD_PACKER_STATS_EN
  logic [31:0]   stat_issued, stat_padded;
`endif

  int n_chk = 0;
  int n_bad = 0;
  logic [W-1:0] va [LANES];
  logic [W-1:0] vb [LANES];

  dsp_simd_packer #(
    .LANES(LANES), .WIDTH(W), .TIMEOUT(TO), .DSP_LATENCY(LAT)
  ) dut (
    .clock_i    (clock),
    .reset_ni   (reset_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_a_i     (in_a),
    .in_b_i     (in_b),
    .vec_valid_o(vec_valid),
    .vec_a_o    (vec_a),
    .vec_b_o    (vec_b),
    .vec_y_i    (vec_y),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_y_o    (out_y),
    .out_lane_o (out_lane)
`ifdef DSP_SIMD_PACKER_STATS_EN
    ,
    .stat_issued_o(stat_issued),
    .stat_padded_o(stat_padded)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [VW-1:0] lane_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*W +: W] = a[i*W +: W] + b[i*W +: W];
    return r;
  endfunction

  // DSP stand-in: the sum is only present on vec_y during the single cycle it is due.
  logic [VW-1:0] dsp_sum = '0;
  int            dsp_cnt = 0;
  always @(posedge clock) begin
    if (vec_valid) begin
      dsp_sum <= lane_add(vec_a, vec_b);
      dsp_cnt <= LAT;
    end else if (dsp_cnt > 0) begin
      dsp_cnt <= dsp_cnt - 1;
    end
  end
  assign vec_y = (dsp_cnt == 1) ? dsp_sum : ~dsp_sum;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One vector: n ops, optional fixed idle gap before the last op, drain with optional stall.
  task automatic run_vec(input int n, input bit directed, input int gap_last,
                         input int hold_lane, input int hold_cycles, input bit rand_bp);
    logic [VW-1:0] ea, eb;
    logic [W-1:0]  ey;
    int k, held, g;
    ea = '0;
    eb = '0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) g = 0;
      else if (i == n - 1 && gap_last >= 0) g = gap_last;
      else if (directed) g = 0;
      else g = $urandom_range(0, TO - 1);
      repeat (g) begin
        in_valid = 1'b0;
        chk("idle_no_issue", vec_valid, 0);
        tick();
      end
      if (!directed) begin
        va[i] = W'($urandom);
        vb[i] = W'($urandom);
      end
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
      chk("in_ready_fill", in_ready, 1);
      chk("no_early_issue", vec_valid, 0);
      tick();
      in_valid = 1'b0;
      ea[i*W +: W] = va[i];
      eb[i*W +: W] = vb[i];
    end
    if (n < LANES) begin
      for (int c = 0; c < TO; c++) begin
        chk("timeout_no_issue", vec_valid, 0);
        chk("timeout_ready", in_ready, 1);
        tick();
      end
    end
    chk("issue_strobe", vec_valid, 1);
    chk("vec_a", vec_a, ea);
    chk("vec_b", vec_b, eb);
    chk("in_ready_wait", in_ready, 0);
    in_valid = 1'b1;
    in_a = W'($urandom);
    in_b = W'($urandom);
    tick();
    chk("strobe_one_cycle", vec_valid, 0);
    for (int c = 0; c < LAT; c++) begin
      chk("lat_no_out", out_valid, 0);
      chk("vec_a_hold", vec_a, ea);
      chk("vec_b_hold", vec_b, eb);
      chk("in_ready_wait", in_ready, 0);
      tick();
    end
    chk("first_out", out_valid, 1);
    k = 0;
    held = 0;
    for (int c = 0; c < 200 && k < n; c++) begin
      if (k == hold_lane && held < hold_cycles) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      in_valid = 1'($urandom_range(0, 1));
      in_a = W'($urandom);
      in_b = W'($urandom);
      ey = va[k] + vb[k];
      chk("out_valid", out_valid, 1);
      chk("out_lane", out_lane, k);
      chk("out_y", out_y, ey);
      chk("in_ready_drain", in_ready, 0);
      if (out_ready) k++;
      tick();
    end
    chk("drain_count", k, n);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("back_to_fill", in_ready, 1);
    chk("out_idle", out_valid, 0);
    chk("vec_a_cleared", vec_a, 0);
    chk("vec_b_cleared", vec_b, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_vec_a", vec_a, 0);
    chk("rst_vec_b", vec_b, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_lane", out_lane, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("release_in_ready", in_ready, 1);

    // Full vector with known operands.
    va[0] = 12'hFFF; vb[0] = 12'h010;
    va[1] = 12'd23;  vb[1] = 12'd7;
    va[2] = 12'd255; vb[2] = 12'd7;
    va[3] = 12'hFEC; vb[3] = 12'hFF9;
    run_vec(4, 1'b1, -1, -1, 0, 1'b0);

    // Two ops then idle: forced issue after TIMEOUT idle cycles.
    run_vec(2, 1'b0, -1, -1, 0, 1'b0);

`ifdef DSP_SIMD_PACKER_STATS_EN
    chk("stat_issued", stat_issued, 2);
    chk("stat_padded", stat_padded, 2);
`endif

    // Drain stalled for 5 cycles on lane 1, then on lane 0.
    run_vec(4, 1'b0, -1, 1, 5, 1'b0);
    run_vec(3, 1'b0, -1, 0, 5, 1'b0);

    // Last lane arrives on the cycle the idle timer would expire.
    run_vec(4, 1'b0, TO - 1, -1, 0, 1'b0);

    // Async reset while waiting on the DSP.
    for (int i = 0; i < LANES; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom);
      in_b = W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_reset_issue", vec_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_vec_valid", vec_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_vec_a", vec_a, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rerelease_in_ready", in_ready, 1);
    for (int c = 0; c < LAT + 4; c++) begin
      chk("no_stale_out", out_valid, 0);
      chk("no_stale_issue", vec_valid, 0);
      tick();
    end

    // Randomized vectors with random drain back-pressure.
    for (int r = 0; r < 16; r++) begin
      run_vec($urandom_range(1, LANES), 1'b0, -1, -1, 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
